// File: rtl/mem_resp_ctrl.sv
// Memory response controller: arbitrates cache instruction/data requests onto one RAM port,
// retries failed RAM accesses and signals completion with single-cycle wait drops.
module mem_resp_ctrl #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    // Widths hold the limit value itself (counters saturate at / compare against it).
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    state_t        state, next_state;
    logic [SW-1:0] starve;
    logic [RW-1:0] retry;
    logic          backoff;
    logic          op_wr;
    logic          src_d;
    logic [31:0]   req_addr;
    logic [31:0]   req_store;

    logic          grant_d, grant_i;
    logic          acc_retry;
    logic          load_en;
    logic [31:0]   load_val;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        acc_retry  = 1'b0;
        load_en    = 1'b0;
        load_val   = ramload;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        case (state)
            IDLE: begin
                if ((dREN || dWEN) && ((starve < STARVE_MAX) || !iREN)) begin
                    grant_d    = 1'b1;
                    next_state = ACC;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    next_state = ACC;
                end
            end

            ACC: begin
                // During backoff the strobes stay low and the RAM status is ignored.
                if (!backoff) begin
                    ramREN = !op_wr;
                    ramWEN = op_wr;
                    if (ramstate == RS_ACCESS) begin
                        load_en    = !op_wr;
                        load_val   = ramload;
                        next_state = RESP;
                    end else if (ramstate == RS_ERROR) begin
                        if (retry < RETRY_MAX) begin
                            acc_retry = 1'b1;
                        end else begin
                            load_en    = !op_wr;
                            load_val   = ERR_WORD;
                            next_state = RESP;
                        end
                    end
                end
            end

            RESP: begin
                iwait      = src_d;
                dwait      = !src_d;
                next_state = IDLE;
            end

            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve    <= '0;
            retry     <= '0;
            backoff   <= 1'b0;
            op_wr     <= 1'b0;
            src_d     <= 1'b0;
            req_addr  <= '0;
            req_store <= '0;
            iload     <= '0;
            dload     <= '0;
        end else begin
            if (grant_d) begin
                req_addr  <= daddr;
                req_store <= dstore;
                op_wr     <= dWEN;
                src_d     <= 1'b1;
                if (!iREN) begin
                    starve <= '0;
                end else if (starve != STARVE_MAX) begin
                    starve <= starve + SW'(1);
                end
            end else if (grant_i) begin
                req_addr <= iaddr;
                op_wr    <= 1'b0;
                src_d    <= 1'b0;
                starve   <= '0;
            end

            // Backoff lasts exactly one cycle: acc_retry is never set while backoff is high.
            backoff <= acc_retry;

            if (state == RESP) begin
                retry <= '0;
            end else if (acc_retry) begin
                retry <= retry + RW'(1);
            end

            if (load_en) begin
                if (src_d) begin
                    dload <= load_val;
                end else begin
                    iload <= load_val;
                end
            end
        end
    end

    assign ramaddr  = req_addr;
    assign ramstore = req_store;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed self-checking bench for mem_resp_ctrl; inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_mem_resp_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    always #5 CLK = ~CLK;

    mem_resp_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        cyc(); cyc();
        n_cmp++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL reset_waits: got i=%b d=%b want 1 1", iwait, dwait); end
        n_cmp++; if (iload !== 32'h0 || dload !== 32'h0) begin n_bad++; $display("FAIL reset_loads: got %h %h want 0 0", iload, dload); end
        n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got %b %b want 0 0", ramREN, ramWEN); end
        n_cmp++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_bad++; $display("FAIL reset_ramaddr: got %h %h want 0 0", ramaddr, ramstore); end
        nRST = 1'b1;
        cyc();
    endtask

    task automatic test_instr_read();
        iREN = 1; iaddr = 32'h40; ramstate = FREE;         // cycle 0
        cyc();                                             // cycle 1
        n_cmp++; if (ramaddr !== 32'h40) begin n_bad++; $display("FAIL iread_addr: got %h want 00000040", ramaddr); end
        for (int c = 1; c <= 3; c++) begin
            n_cmp++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin n_bad++; $display("FAIL iread_ren_c%0d: got %b/%b want 1/0", c, ramREN, ramWEN); end
            n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL iread_early_c%0d: got iwait %b want 1", c, iwait); end
            if (c == 3) begin ramstate = ACCESS; ramload = 32'h8C010004; end
            else ramstate = BUSY;
            cyc();
        end
        // cycle 4
        n_cmp++; if (iwait !== 1'b0 || dwait !== 1'b1) begin n_bad++; $display("FAIL iread_resp: got i=%b d=%b want 0 1", iwait, dwait); end
        n_cmp++; if (iload !== 32'h8C010004) begin n_bad++; $display("FAIL iread_iload: got %h want 8c010004", iload); end
        n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL iread_resp_strobe: got %b want 0", ramREN); end
        iREN = 0; ramstate = FREE;
        cyc();
        n_cmp++; if (iwait !== 1'b1 || iload !== 32'h8C010004) begin n_bad++; $display("FAIL iread_hold: got iwait=%b iload=%h want 1 8c010004", iwait, iload); end
    endtask

    task automatic test_data_write();
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = ACCESS; ramload = 32'h13579BDF;
        cyc();                                             // cycle 1
        n_cmp++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_bad++; $display("FAIL dwrite_strobe: got wen=%b ren=%b want 1 0", ramWEN, ramREN); end
        n_cmp++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dwrite_bus: got %h %h want 00000100 deadbeef", ramaddr, ramstore); end
        dWEN = 0; daddr = 32'hFFFF0000; dstore = 32'h0;
        cyc();                                             // cycle 2
        n_cmp++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_bad++; $display("FAIL dwrite_resp: got d=%b i=%b want 0 1", dwait, iwait); end
        n_cmp++; if (dload !== 32'h0) begin n_bad++; $display("FAIL dwrite_dload: got %h want 00000000", dload); end
        ramstate = FREE;
        cyc();
        n_cmp++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin n_bad++; $display("FAIL dwrite_after: got dwait=%b wen=%b want 1 0", dwait, ramWEN); end
    endtask

    task automatic test_arbitration();
        string exp_order = "DDDDID";
        byte   got;
        int    waited;
        nRST = 0; cyc(); nRST = 1; cyc();
        iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h800; ramstate = ACCESS; ramload = 32'h11;
        for (int t = 0; t < 6; t++) begin
            got = "-";
            waited = 0;
            while (got == "-" && waited < 6) begin
                cyc();
                waited++;
                n_cmp++; if (!iwait && !dwait) begin n_bad++; $display("FAIL arb_both_low: got i=%b d=%b want not both 0", iwait, dwait); end
                if (!dwait) got = "D";
                else if (!iwait) got = "I";
            end
            n_cmp++; if (got != exp_order[t]) begin n_bad++; $display("FAIL arb_grant_%0d: got %c want %c", t, got, exp_order[t]); end
        end
        iREN = 0; dREN = 0; ramstate = FREE;
        cyc();
    endtask

    task automatic test_error_retry();
        // Two errors, then success.
        dREN = 1; daddr = 32'h200; ramstate = ERROR;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c == 1) dREN = 0;
            n_cmp++; if (ramREN !== logic'(c % 2)) begin n_bad++; $display("FAIL err2_ren_c%0d: got %b want %0d", c, ramREN, c % 2); end
            if (c == 5) begin ramstate = ACCESS; ramload = 32'h1234; end
        end
        cyc();
        n_cmp++; if (dwait !== 1'b0 || dload !== 32'h1234) begin n_bad++; $display("FAIL err2_resp: got dwait=%b dload=%h want 0 00001234", dwait, dload); end
        ramstate = FREE;
        cyc();
        n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL err2_single: got dwait=%b want 1", dwait); end

        // Four errors: retries exhausted.
        dREN = 1; daddr = 32'h204; ramstate = ERROR;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) dREN = 0;
            n_cmp++; if (ramREN !== logic'(c % 2) || dwait !== 1'b1) begin n_bad++; $display("FAIL err4_c%0d: got ren=%b dwait=%b want %0d 1", c, ramREN, dwait, c % 2); end
        end
        cyc();
        n_cmp++; if (dwait !== 1'b0 || dload !== 32'hBAD1BAD1) begin n_bad++; $display("FAIL err4_resp: got dwait=%b dload=%h want 0 bad1bad1", dwait, dload); end
        ramstate = FREE;
        cyc();

        // Retry count starts fresh: one error then success.
        dREN = 1; daddr = 32'h208; ramstate = ERROR;
        cyc(); dREN = 0;                                   // issue, ERROR
        cyc();                                             // backoff
        n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL err1_backoff: got %b want 0", ramREN); end
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        cyc();                                             // re-issue, ACCESS
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'h208) begin n_bad++; $display("FAIL err1_reissue: got ren=%b addr=%h want 1 00000208", ramREN, ramaddr); end
        cyc();
        n_cmp++; if (dwait !== 1'b0 || dload !== 32'hCAFE0001) begin n_bad++; $display("FAIL err1_resp: got dwait=%b dload=%h want 0 cafe0001", dwait, dload); end
        ramstate = FREE;
        cyc();
    endtask

    task automatic test_mid_access_reset();
        iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        cyc();
        n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL rst_pre_ren: got %b want 1", ramREN); end
        cyc();
        nRST = 0;
        #1;
        n_cmp++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin n_bad++; $display("FAIL rst_async_ram: got ren=%b wen=%b addr=%h want 0 0 0", ramREN, ramWEN, ramaddr); end
        n_cmp++; if (iwait !== 1'b1 || dwait !== 1'b1) begin n_bad++; $display("FAIL rst_async_wait: got %b %b want 1 1", iwait, dwait); end
        n_cmp++; if (iload !== 32'h0 || dload !== 32'h0) begin n_bad++; $display("FAIL rst_async_load: got %h %h want 0 0", iload, dload); end
        iREN = 0; ramstate = ACCESS;
        cyc(); nRST = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_cmp++; if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0) begin n_bad++; $display("FAIL rst_no_pulse_c%0d: got i=%b d=%b ren=%b want 1 1 0", c, iwait, dwait, ramREN); end
        end
        dREN = 1; daddr = 32'h300; ramload = 32'h55AA;
        cyc(); dREN = 0;
        cyc();
        n_cmp++; if (dwait !== 1'b0 || dload !== 32'h55AA) begin n_bad++; $display("FAIL rst_next_req: got dwait=%b dload=%h want 0 000055aa", dwait, dload); end
        ramstate = FREE;
        cyc();
    endtask

    task automatic test_withdrawn();
        iREN = 1; iaddr = 32'hC0; ramstate = BUSY;
        cyc();                                             // cycle 1
        cyc();                                             // cycle 2
        iREN = 0; iaddr = 32'h0;
        cyc();                                             // cycle 3
        n_cmp++; if (ramREN !== 1'b1 || ramaddr !== 32'hC0) begin n_bad++; $display("FAIL wd_still_acc: got ren=%b addr=%h want 1 000000c0", ramREN, ramaddr); end
        ramstate = ACCESS; ramload = 32'h77;
        cyc();                                             // cycle 4
        n_cmp++; if (iwait !== 1'b0 || iload !== 32'h77) begin n_bad++; $display("FAIL wd_resp: got iwait=%b iload=%h want 0 00000077", iwait, iload); end
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_cmp++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin n_bad++; $display("FAIL wd_idle_c%0d: got iwait=%b ren=%b want 1 0", c, iwait, ramREN); end
        end
        ramstate = FREE;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_arbitration();
        test_error_retry();
        test_mid_access_reset();
        test_withdrawn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_resp_ctrl.md
Name: mem_resp_ctrl

Overview:
- Responder end of the caches-to-memory request interface. It services instruction reads (iREN/iaddr) and data reads and writes (dREN/dWEN/daddr/dstore) from the cache side.
- It arbitrates the two request sources onto a single RAM port and signals completion by dropping iwait or dwait.
- It sits between the caches block and the RAM model, and replaces the pass-through memory control path with a registered, latency-tolerant FSM that retries accesses the RAM reports as failed.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced.
- MAX_RETRY, 3: number of re-issues after ramstate=ERROR before the access completes with ERR_WORD.
- ERR_WORD, 32'hBAD1BAD1: load value returned when retries are exhausted.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- iaddr  in  32  instruction address.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iwait  out  1  low for one cycle when an instruction read completes.
- dwait  out  1  low for one cycle when a data access completes.
- iload  out  32  registered instruction word; valid while iwait=0.
- dload  out  32  registered data word; valid while dwait=0 after a read.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address, taken from the latched request.
- ramstore  out  32  RAM write data, taken from the latched request.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (asynchronous, nRST=0):
  - state=IDLE.
  - iwait=1, dwait=1.
  - iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - starve counter and retry counter cleared.
  - An in-flight access is abandoned; no response pulse is produced.
- States: IDLE, ACC, RESP.
- IDLE:
  - If dREN|dWEN and (starve<STARVE_LIMIT or !iREN): latch daddr, dstore and op (a write if dWEN; dWEN wins if both dREN and dWEN are set); src=D; go to ACC.
  - Else if iREN: latch iaddr, op=read; src=I; go to ACC.
  - Else remain in IDLE.
- ACC:
  - Drive ramaddr/ramstore from the latched request; ramREN=(op==read), ramWEN=(op==write).
  - ramstate FREE or BUSY: remain in ACC.
  - ramstate ACCESS:
    - On a read, register ramload into iload (src=I) or dload (src=D).
    - On a write, dload is unchanged.
    - Go to RESP.
  - ramstate ERROR:
    - If retry<MAX_RETRY: retry++, drop strobes for one cycle (internal backoff bit), then re-issue.
    - Else: register ERR_WORD into the load register (reads only) and go to RESP.
- RESP:
  - Exactly one cycle with iwait=0 (src=I) or dwait=0 (src=D); RAM strobes are low.
  - Clear retry; go to IDLE.
  - Arbitration in IDLE re-evaluates the next cycle; no request is accepted during RESP.
- Starve counter:
  - Increments on each data grant made while iREN=1.
  - Clears on any instruction grant, and on a data grant made while iREN=0.
  - Saturates at STARVE_LIMIT.
- Wait outputs: iwait and dwait are 1 in every state except the matching RESP cycle; they are never both 0.
- Latched request: changes on the cache-side inputs after the grant are ignored. A request withdrawn mid-access still completes on the RAM and still produces its RESP pulse.
- Minimum latency: request visible in IDLE at cycle 0; ACC at cycle 1. With ramstate=ACCESS at cycle 1, the wait line is low at cycle 2. Each extra BUSY cycle adds one cycle.
- iload and dload hold their value outside RESP.

Test Plan:
- Instruction read: iREN=1, iaddr=0x40, RAM returns 0x8C010004 after 2 BUSY cycles -> iwait=0 for exactly one cycle at cycle 4 with iload=0x8C010004; ramREN=1 during cycles 1-3.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, immediate ACCESS -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF at cycle 1; dwait=0 at cycle 2; iwait stays 1.
- Simultaneous requests with iREN and dREN held high, every access immediate -> grant order D,D,D,D,I,D,…; the I grant follows the 4th consecutive D grant (STARVE_LIMIT=4).
- ERROR retry: dREN=1, ramstate=ERROR on the first two issues then ACCESS with 0x1234 -> two strobe drop cycles; dload=0x1234 with dwait=0 once. With four consecutive ERRORs -> dload=0xBAD1BAD1.
- Mid-access reset: nRST driven low while in ACC with BUSY -> strobes, waits and loads take their reset values immediately; no wait pulse after release; the next request is served normally.
- Withdrawn request: iREN drops in cycle 2 while ACC is waiting on BUSY -> the access still completes and iwait pulses low once; then IDLE.
